// File: rtl/seq_det_if.sv
// Host/stream-side bundle for the programmable serial pattern detector.
// The master drives configuration, control and the bit stream; the slave reports status.
interface seq_det_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    logic               cfg_wr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, in_valid, in,
        input  busy, match, match_cnt, done, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, in_valid, in,
        output busy, match, match_cnt, done, cfg_err
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: loadable pattern/length/overlap/target,
// IDLE/RUN/DONE sequencing, match counting and a done pulse at the target count.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_det_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0]         MAX_LEN4 = 4'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(11);

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [3:0]         len;
    logic               overlap;
    logic [CNT_W-1:0]   target;
    logic [MAX_LEN-1:0] window;
    logic [3:0]         fill;
    logic               match;
    logic               done;
    logic               busy;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    logic [MAX_LEN-1:0] window_nxt;
    logic [3:0]         fill_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;
    logic               cfg_legal;

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [3:0] l);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) < l) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Next window/fill as if the current bit were accepted; the match is judged on these.
    always_comb begin
        window_nxt = {window[MAX_LEN-2:0], bus.in};
        fill_nxt   = (fill >= len) ? len : 4'(fill + 4'd1);
        cnt_inc    = match_cnt + 1'b1;
        hit        = bus.in_valid && (fill_nxt == len) &&
                     (((window_nxt ^ pattern) & len_mask(len)) == '0);
        cfg_legal  = (bus.cfg_len != 4'd0) && (bus.cfg_len <= MAX_LEN4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pattern   <= PAT_RST;
            len       <= 4'd4;
            overlap   <= 1'b1;
            target    <= '0;
            window    <= '0;
            fill      <= '0;
            match     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (bus.cfg_wr) begin
                        if (cfg_legal) begin
                            pattern <= bus.cfg_pattern;
                            len     <= bus.cfg_len;
                            overlap <= bus.cfg_overlap;
                            target  <= bus.cfg_target;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    if (bus.start && !bus.abort) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        match_cnt <= '0;
                        window    <= '0;
                        fill      <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // A match completing on the abort edge is dropped; the count is kept.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.in_valid) begin
                        window <= window_nxt;
                        if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= cnt_inc;
                            fill      <= overlap ? len : 4'd0;
                            if (target != '0 && cnt_inc == target) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            fill <= fill_nxt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.match     = match;
    assign bus.match_cnt = match_cnt;
    assign bus.done      = done;
    assign bus.cfg_err   = cfg_err;
endmodule
